// File: rtl/freq_bcd_conv.sv
// Binary frequency word to six packed BCD digits via an iterative shift-add-3 sequencer.
// Optional build macro FREQ_BCD_LZ_BLANK_EN: digit_en blanks leading zeros instead of enabling all digits.
//
// state | meaning
// IDLE  | waiting for data_valid, outputs hold last result
// SHIFT | one add-3/shift step per clock, DATA_W steps total
// DONE  | bcd_valid high for this cycle, busy drops on exit
module freq_bcd_conv #(
    parameter int                DATA_W  = 20,
    parameter int                DIG_N   = 6,
    parameter logic [DATA_W-1:0] MAX_VAL = 20'd999_999
) (
    input  logic                 clk_fs,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 data_valid,
    output logic                 busy,
    output logic [4*DIG_N-1:0]   bcd_out,
    output logic                 bcd_valid,
    output logic                 ovf,
    output logic [DIG_N-1:0]     digit_en
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_W-1:0]    sat;
    logic [4*DIG_N-1:0]   scratch;
    logic [4*DIG_N-1:0]   scratch_adj;
    logic [4*DIG_N-1:0]   scratch_nxt;
    logic [4:0]           cnt;
    logic                 ovf_pend;
    logic                 last_shift;
    logic                 over_max;
    logic [DIG_N-1:0]     den_nxt;

    assign over_max   = (data_in > MAX_VAL);
    assign last_shift = (cnt == 5'(DATA_W - 1));

    // Nibbles are <=9 here, so the 4-bit add never needs a carry out.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIG_N; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        scratch_nxt = {scratch_adj[4*DIG_N-2:0], sat[DATA_W-1]};
    end

`ifdef FREQ_BCD_LZ_BLANK_EN
    always_comb begin
        logic nz;
        nz      = 1'b0;
        den_nxt = '0;
        for (int k = DIG_N - 1; k >= 1; k--) begin
            nz         = nz | (|scratch_nxt[4*k +: 4]);
            den_nxt[k] = nz;
        end
        den_nxt[0] = 1'b1;
    end
`else
    always_comb begin
        den_nxt = '1;
    end
`endif

    always_ff @(posedge clk_fs) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_valid) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_fs) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            bcd_valid <= 1'b0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
            digit_en  <= {{(DIG_N-1){1'b0}}, 1'b1};
            sat       <= '0;
            scratch   <= '0;
            cnt       <= '0;
            ovf_pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        sat      <= over_max ? MAX_VAL : data_in;
                        ovf_pend <= over_max;
                        scratch  <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    sat     <= {sat[DATA_W-2:0], 1'b0};
                    cnt     <= cnt + 5'd1;
                    if (last_shift) begin
                        bcd_out   <= scratch_nxt;
                        ovf       <= ovf_pend;
                        digit_en  <= den_nxt;
                        bcd_valid <= 1'b1;
                    end
                end
                DONE: begin
                    bcd_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_bcd_conv.sv
// Bench for freq_bcd_conv: table vectors, handshake corner sequences and a random sweep,
// with results checked through an expected-result queue drained on each bcd_valid.
module tb_freq_bcd_conv;

    logic        clk_fs = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        busy;
    logic [23:0] bcd_out;
    logic        bcd_valid;
    logic        ovf;
    logic [5:0]  digit_en;

    freq_bcd_conv dut (
        .clk_fs     (clk_fs),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .busy       (busy),
        .bcd_out    (bcd_out),
        .bcd_valid  (bcd_valid),
        .ovf        (ovf),
        .digit_en   (digit_en)
    );

    always #5 clk_fs = ~clk_fs;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        logic [5:0]  den;
        int          acc;
    } exp_t;

    typedef struct {
        logic [19:0] din;
        logic [23:0] bcd;
        logic        ovf;
        logic [5:0]  den_lz;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [5:0] pick_den(input logic [5:0] lz);
`ifdef FREQ_BCD_LZ_BLANK_EN
        return lz;
`else
        return 6'h3F;
`endif
    endfunction

    // Decimal reference: clamp, then peel digits with divide/modulo.
    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned t;
        logic [5:0]  lz;
        logic        nz;
        t     = (v > 999999) ? 999999 : v;
        e.ovf = (v > 999999);
        e.bcd = '0;
        for (int i = 0; i < 6; i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        nz = 1'b0;
        lz = 6'h01;
        for (int k = 5; k >= 1; k--) begin
            nz    = nz | (e.bcd[4*k +: 4] != 4'd0);
            lz[k] = nz;
        end
        e.den = pick_den(lz);
        e.acc = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk_fs);
        #1;
    endtask

    // One-cycle request; queued only if the DUT will actually take it.
    task automatic req(input logic [19:0] d, input exp_t e);
        data_in    = d;
        data_valid = 1'b1;
        if (!busy && rst_n) begin
            e.acc = cyc + 1;
            sbq.push_back(e);
        end
        tick();
        data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_one(input logic [19:0] d, input exp_t e);
        int n;
        req(d, e);
        n = 0;
        while (busy && n < 60) begin
            n++;
            tick();
        end
        chk("busy_len", n, 21);
    endtask

    // Monitor: scoreboard drain, pulse width, and output hold between pulses.
    logic [30:0] prev_out = '0;
    logic        prev_valid = 1'b0;
    initial begin
        logic r;
        exp_t e;
        forever begin
            @(posedge clk_fs);
            r = rst_n;
            cyc++;
            #1;
            if (bcd_valid) begin
                chk("valid_width", {31'd0, prev_valid}, 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", {31'd0, bcd_valid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("bcd_out", {8'd0, bcd_out}, {8'd0, e.bcd});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                    chk("digit_en", {26'd0, digit_en}, {26'd0, e.den});
                    chk("latency", cyc - e.acc, 20);
                end
            end else if (r) begin
                chk("hold", {1'b0, bcd_out, ovf, digit_en}, {1'b0, prev_out});
            end
            prev_out   = {bcd_out, ovf, digit_en};
            prev_valid = bcd_valid;
        end
    end

    vec_t vecs[9];

    initial begin
        exp_t e;
        int unsigned v;

        vecs[0] = '{20'd0,       24'h000000, 1'b0, 6'h01};
        vecs[1] = '{20'd123456,  24'h123456, 1'b0, 6'h3F};
        vecs[2] = '{20'd1048575, 24'h999999, 1'b1, 6'h3F};
        vecs[3] = '{20'd1000000, 24'h999999, 1'b1, 6'h3F};
        vecs[4] = '{20'd999999,  24'h999999, 1'b0, 6'h3F};
        vecs[5] = '{20'd123,     24'h000123, 1'b0, 6'h07};
        vecs[6] = '{20'd500,     24'h000500, 1'b0, 6'h07};
        vecs[7] = '{20'd9,       24'h000009, 1'b0, 6'h01};
        vecs[8] = '{20'd1000,    24'h001000, 1'b0, 6'h0F};

        repeat (2) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, bcd_valid}, 32'd0);
        chk("rst_bcd", {8'd0, bcd_out}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_den", {26'd0, digit_en}, 32'h01);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            e.bcd = vecs[i].bcd;
            e.ovf = vecs[i].ovf;
            e.den = pick_den(vecs[i].den_lz);
            e.acc = 0;
            run_one(vecs[i].din, e);
            tick();
        end

        // Requests at the 5th and 21st edges are dropped; the 22nd-edge one is taken.
        e = model(500);
        req(20'd500, e);
        repeat (4) tick();
        req(20'd777, model(777));
        repeat (15) tick();
        chk("done_busy", {31'd0, busy}, 32'd1);
        req(20'd777, model(777));
        chk("after_done_busy", {31'd0, busy}, 32'd0);
        req(20'd777, model(777));
        wait_idle();
        tick();

        // Reset mid-conversion discards the word.
        req(20'd654321, model(654321));
        repeat (9) tick();
        rst_n = 1'b0;
        sbq.delete();
        tick();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, bcd_valid}, 32'd0);
        chk("mid_rst_bcd", {8'd0, bcd_out}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        chk("mid_rst_den", {26'd0, digit_en}, 32'h01);
        rst_n = 1'b1;
        repeat (25) tick();
        run_one(20'd42, model(42));
        tick();

        for (int i = 0; i < 1000; i++) begin
            v = $urandom_range(0, 1048575);
            run_one(20'(v), model(v));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
